ma_request_arbiter: RTL and testbench

- Shares the single Memory Access (MA) request port between up to four pipeline stages, such as FindOrInsert (stage ID 1) and its sibling stages.
- Round-robin arbitration feeds a one-deep registered output stage. The granted stage ID goes out on aso_request_channel.
- A per-stage outstanding-response counter throttles requesters that expect MA results.
- MA results are registered and demultiplexed back to the owning stage by asi_result_channel.

---
 rtl/ma_request_arbiter_if.sv | 33 +++
 rtl/ma_request_arbiter.sv | 99 +++++++++
 tb/tb_ma_request_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ma_request_arbiter_if.sv
// Bundles the requester-side, MA-side and result-side signals of the MA request arbiter.
// The slave modport is the arbiter's view; master is the view of the logic driving it.
interface ma_request_arbiter_if;
  logic [511:0] req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_expect;
  logic [3:0]   req_ready;
  logic [127:0] aso_request_data;
  logic [1:0]   aso_request_channel;
  logic         aso_request_valid;
  logic         aso_request_ready;
  logic [95:0]  asi_result_data;
  logic [1:0]   asi_result_channel;
  logic         asi_result_valid;
  logic         asi_result_ready;
  logic [95:0]  res_data;
  logic [3:0]   res_valid;
  logic         outstanding_err;

  modport slave (
    input  req_data, req_valid, req_expect, aso_request_ready,
           asi_result_data, asi_result_channel, asi_result_valid,
    output req_ready, aso_request_data, aso_request_channel, aso_request_valid,
           asi_result_ready, res_data, res_valid, outstanding_err
  );

  modport master (
    output req_data, req_valid, req_expect, aso_request_ready,
           asi_result_data, asi_result_channel, asi_result_valid,
    input  req_ready, aso_request_data, aso_request_channel, aso_request_valid,
           asi_result_ready, res_data, res_valid, outstanding_err
  );
endinterface

// File: rtl/ma_request_arbiter.sv
// Round-robin arbiter sharing one MA request port among four pipeline stages, with
// per-stage outstanding-result throttling and a registered result demultiplexer.
module ma_request_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                 clk,
  input logic                 reset,
  ma_request_arbiter_if.slave bus
);

  localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

  logic [2:0]         cnt [NUM_REQ];
  logic [1:0]         last;
  logic [1:0]         winner;
  logic               anyElig;
  logic               load;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;
  logic [NUM_REQ-1:0] underflow;

  assign load = !bus.aso_request_valid || bus.aso_request_ready;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
    elig      = '0;
    inc       = '0;
    dec       = '0;
    underflow = '0;
    winner    = '0;
    anyElig   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && !(bus.req_expect[i] && cnt[i] == MaxCnt);
    end
    // Scan starts just after the last winner and wraps; k==NUM_REQ revisits last itself.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!anyElig && elig[last + 2'(k)]) begin
        winner  = last + 2'(k);
        anyElig = 1'b1;
      end
    end
    grant = (load && anyElig) ? (4'b0001 << winner) : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i]       = grant[i] && bus.req_expect[i];
      dec[i]       = bus.asi_result_valid && bus.asi_result_channel == 2'(i);
      underflow[i] = dec[i] && cnt[i] == 3'd0;
    end
  end

  assign bus.req_ready        = grant;
  assign bus.asi_result_ready = 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      bus.aso_request_valid   <= 1'b0;
      bus.aso_request_data    <= '0;
      bus.aso_request_channel <= '0;
      last                    <= 2'd3;
    end else if (load) begin
      if (anyElig) begin
        bus.aso_request_valid   <= 1'b1;
        bus.aso_request_data    <= bus.req_data[128*winner +: 128];
        bus.aso_request_channel <= winner;
        last                    <= winner;
      end else begin
        bus.aso_request_valid <= 1'b0;
      end
    end
  end

  // Simultaneous inc and dec cancel; a dec at zero saturates and flags the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      bus.outstanding_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i])                     cnt[i] <= cnt[i] + 3'd1;
        else if (dec[i] && !inc[i] && !underflow[i]) cnt[i] <= cnt[i] - 3'd1;
      end
      if (|underflow) bus.outstanding_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.res_data  <= '0;
      bus.res_valid <= '0;
    end else begin
      if (bus.asi_result_valid) bus.res_data <= bus.asi_result_data;
      bus.res_valid <= bus.asi_result_valid ? (4'b0001 << bus.asi_result_channel) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_ma_request_arbiter.sv
// Self-checking bench for ma_request_arbiter: directed vector table plus randomized
// traffic compared every cycle against a behavioural model of the arbitration rules.
module tb_ma_request_arbiter;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ma_request_arbiter_if bus();

  ma_request_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nVec = 0;
  int nErr = 0;

  // Behavioural model state
  int           mCnt [4];
  int           mLast;
  logic         mAValid;
  logic [127:0] mAData;
  int           mACh;
  logic [95:0]  mRes;
  logic [3:0]   mResV;
  logic         mErr;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] e;
    logic       mr;
    logic       rv;
    logic [1:0] rc;
    logic [3:0] xReady;
    logic       xAValid;
    logic [1:0] xCh;
    logic [3:0] xResV;
    logic       xErr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mCnt[i] = 0;
    mLast   = 3;
    mAValid = 1'b0;
    mAData  = '0;
    mACh    = 0;
    mRes    = '0;
    mResV   = '0;
    mErr    = 1'b0;
  endtask

  // One clock cycle: drive inputs, check req_ready, clock, then check registered outputs.
  task automatic cycle(input logic rst, input logic [3:0] v, input logic [3:0] e,
                       input logic mr, input logic rv, input logic [1:0] rc,
                       input logic [511:0] d, input logic [95:0] rd,
                       output logic [3:0] gotReady);
    bit         load;
    int         win;
    logic [3:0] xr;
    reset                  = rst;
    bus.req_valid          = v;
    bus.req_expect         = e;
    bus.req_data           = d;
    bus.aso_request_ready  = mr;
    bus.asi_result_valid   = rv;
    bus.asi_result_channel = rc;
    bus.asi_result_data    = rd;

    load = !mAValid || mr;
    win  = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx = (mLast + k) % 4;
      if (win < 0 && v[idx] && !(e[idx] && mCnt[idx] == MAXO)) win = idx;
    end
    xr = (load && win >= 0) ? 4'(1 << win) : 4'b0000;

    #2;
    gotReady = bus.req_ready;
    check("req_ready", 128'(gotReady), 128'(xr));

    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (load) begin
        if (win >= 0) begin
          mAValid = 1'b1;
          mAData  = d[128*win +: 128];
          mACh    = win;
          mLast   = win;
        end else begin
          mAValid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        bit inc = xr[i] && e[i];
        bit dec = rv && (int'(rc) == i);
        if (dec && mCnt[i] == 0) mErr = 1'b1;
        if (inc && !dec) mCnt[i] = mCnt[i] + 1;
        else if (dec && !inc && mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
      end
      if (rv) begin
        mRes  = rd;
        mResV = 4'(1 << rc);
      end else begin
        mResV = 4'b0000;
      end
    end

    #1;
    check("aso_valid",    128'(bus.aso_request_valid),   128'(mAValid));
    check("aso_channel",  128'(bus.aso_request_channel), 128'(mACh));
    check("aso_data",     bus.aso_request_data,          mAData);
    check("res_valid",    128'(bus.res_valid),           128'(mResV));
    check("res_data",     128'(bus.res_data),            128'(mRes));
    check("err",          128'(bus.outstanding_err),     128'(mErr));
    check("result_ready", 128'(bus.asi_result_ready),    128'(1'b1));
  endtask

  task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] e,
                     input logic mr, input logic rv, input logic [1:0] rc,
                     input logic [3:0] xReady, input logic xAValid, input logic [1:0] xCh,
                     input logic [3:0] xResV, input logic xErr);
    vec_t t;
    t.rst = rst; t.v = v; t.e = e; t.mr = mr; t.rv = rv; t.rc = rc;
    t.xReady = xReady; t.xAValid = xAValid; t.xCh = xCh; t.xResV = xResV; t.xErr = xErr;
    tbl.push_back(t);
  endtask

  initial begin
    logic [511:0] d;
    logic [95:0]  rd;
    logic [3:0]   got;

    //   rst v        e        mr   rv   rc     ready    av   ch     resV     err
    // single requester
    add(0, 4'b0010, 4'b0000, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd1, 4'b0000, 0);
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    // round robin from reset
    add(0, 4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    // back-pressure for five cycles, then requester 2 wins
    for (int i = 0; i < 5; i++)
      add(0, 4'b0101, 4'b0000, 0, 0, 2'd0, 4'b0000, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b0101, 4'b0000, 1, 0, 2'd0, 4'b0100, 1, 2'd2, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd2, 4'b0000, 0);
    // throttle requester 1 at two outstanding while requester 3 flows
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b1010, 4'b0010, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    add(0, 4'b1010, 4'b0010, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 0);
    add(0, 4'b1010, 4'b0010, 1, 1, 2'd1, 4'b1000, 1, 2'd3, 4'b0010, 0);
    add(0, 4'b1010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    // bring count to 1, then grant and result on channel 1 together
    add(0, 4'b0000, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 2'd1, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 1, 1, 2'd1, 4'b0010, 1, 2'd1, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0000, 0, 2'd1, 4'b0000, 0);
    // result for channel 0 at count 0: sticky error
    add(0, 4'b0000, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 2'd1, 4'b0001, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd1, 4'b0000, 1);
    // reset with a held request and nonzero counters
    add(0, 4'b1010, 4'b0010, 1, 0, 2'd0, 4'b1000, 1, 2'd3, 4'b0000, 1);
    add(0, 4'b1010, 4'b0010, 0, 0, 2'd0, 4'b0000, 1, 2'd3, 4'b0000, 1);
    add(1, 4'b1010, 4'b0010, 0, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 0);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd0, 4'b0001, 1, 2'd0, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 2'd1, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0000, 0, 2'd1, 4'b0000, 0);

    // Initial reset, establishing known DUT and model state.
    reset                  = 1'b1;
    bus.req_valid          = '0;
    bus.req_expect         = '0;
    bus.req_data           = '0;
    bus.aso_request_ready  = 1'b0;
    bus.asi_result_valid   = 1'b0;
    bus.asi_result_channel = '0;
    bus.asi_result_data    = '0;
    @(posedge clk);
    #1;
    modelReset();

    for (int w = 0; w < 16; w++) d[32*w +: 32] = 32'hC0DE_0000 + 32'(w);
    foreach (tbl[n]) begin
      rd = {32'(n), 32'hFACE_0000 + 32'(n), 32'h1234_5678 ^ 32'(n)};
      cycle(tbl[n].rst, tbl[n].v, tbl[n].e, tbl[n].mr, tbl[n].rv, tbl[n].rc, d, rd, got);
      check($sformatf("tbl%0d_ready", n), 128'(got),                     128'(tbl[n].xReady));
      check($sformatf("tbl%0d_valid", n), 128'(bus.aso_request_valid),   128'(tbl[n].xAValid));
      check($sformatf("tbl%0d_chan", n),  128'(bus.aso_request_channel), 128'(tbl[n].xCh));
      check($sformatf("tbl%0d_resv", n),  128'(bus.res_valid),           128'(tbl[n].xResV));
      check($sformatf("tbl%0d_err", n),   128'(bus.outstanding_err),     128'(tbl[n].xErr));
    end

    // Randomized traffic against the model; results mostly target channels with work in flight.
    for (int n = 0; n < 3000; n++) begin
      logic       rst, mr, rv;
      logic [3:0] v, e;
      logic [1:0] rc;
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
      rd  = {$urandom, $urandom, $urandom};
      v   = 4'($urandom);
      e   = 4'($urandom);
      mr  = ($urandom_range(3) != 0);
      rst = ($urandom_range(199) == 0);
      rc  = 2'($urandom_range(3));
      rv  = ($urandom_range(2) == 0) && (mCnt[rc] > 0 || $urandom_range(19) == 0);
      cycle(rst, v, e, mr, rv, rc, d, rd, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
